// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial shifter with a clock-enable strobe for a downstream shift register
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             R,
    input  logic [WIDTH-1:0] DIN,
    input  logic             LOAD,
    output logic             READY,
    output logic             SO,
    output logic             SCE,
    output logic             BUSY,
    output logic             DONE
);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state, w_state_nxt;
    logic [DW-1:0]    r_div, w_div_nxt;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_sh, w_sh_nxt;
    logic             r_sce, r_done;
    logic             w_accept, w_last;

    assign w_accept  = (r_state == IDLE) && LOAD;
    assign w_last    = (r_state == SHIFT) && r_sce && (r_bit == BIT_MAX);
    assign w_div_nxt = (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
    // Zero fill means the register is already empty after the last bit, so SO drops to 0 on its own
    assign w_sh_nxt  = LSB_FIRST ? {1'b0, r_sh[WIDTH-1:1]} : {r_sh[WIDTH-2:0], 1'b0};

    // State register
    always_ff @(posedge CLK) begin
        r_state <= R ? IDLE : w_state_nxt;
    end

    // Next state: leave IDLE on an accepted word, return after the strobe of the final bit
    always_comb begin
        w_state_nxt = w_accept ? SHIFT : w_last ? IDLE : r_state;
    end

    // Outputs: status decodes the state register, data and strobes come straight from registers
    always_comb begin
        READY = (r_state == IDLE);
        BUSY  = (r_state == SHIFT);
        SO    = LSB_FIRST ? r_sh[0] : r_sh[WIDTH-1];
        SCE   = r_sce;
        DONE  = r_done;
    end

    // Datapath: capture, bit-period divider, strobe one cycle ahead of the wrap, shift on each strobe
    always_ff @(posedge CLK) begin
        if (R) begin
            r_sh   <= '0;
            r_div  <= '0;
            r_bit  <= '0;
            r_sce  <= 1'b0;
            r_done <= 1'b0;
        end else if (w_accept) begin
            r_sh   <= DIN;
            r_div  <= '0;
            r_bit  <= '0;
            r_sce  <= (DIV == 1);
            r_done <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_div  <= w_div_nxt;
            r_done <= w_last;
            r_sce  <= !w_last && (w_div_nxt == DIV_MAX);
            if (r_sce) begin
                r_sh  <= w_sh_nxt;
                r_bit <= w_last ? '0 : r_bit + 1'b1;
            end
        end else begin
            r_sce  <= 1'b0;
            r_done <= 1'b0;
        end
    end
endmodule
